// File: rtl/tt_pkg.sv
// ============================================================================
// tt_pkg : shared types and constants for the TT query scheduler
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

package tt_pkg;

   localparam int c_stn_w = 4;
   localparam logic [c_stn_w-1:0] c_cost_unreach = '0;

   typedef struct packed {
      logic [c_stn_w-1:0] src;
      logic [c_stn_w-1:0] dst;
   } beat_t;

   typedef enum logic [2:0] {
      ST_ARB     = 3'd0,
      ST_COLLECT = 3'd1,
      ST_REPLAY  = 3'd2,
      ST_WAIT    = 3'd3,
      ST_RESP    = 3'd4
   } state_t;

endpackage

`default_nettype wire

// File: rtl/tt_rr_arbiter.sv
// ============================================================================
// tt_rr_arbiter : combinational round-robin pick, one-hot grant plus index
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module tt_rr_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int ID_W    = 2
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [ID_W-1:0]    ptr,
   output logic [NUM_REQ-1:0] grant,
   output logic [ID_W-1:0]    idx
);

   // Scan starts at ptr and wraps; the first asserted request wins.
   always_comb begin
      int k;
      logic found;
      grant = '0;
      idx   = '0;
      found = 1'b0;
      k     = 0;
      for (int i = 0; i < NUM_REQ; i++) begin
         k = (int'(ptr) + i) % NUM_REQ;
         if (!found && req[k]) begin
            found    = 1'b1;
            grant[k] = 1'b1;
            idx      = ID_W'(k);
         end
      end
   end

endmodule

`default_nettype wire

// File: rtl/tt_query_sched.sv
// ============================================================================
// tt_query_sched : round-robin sharing of one TT engine between requesters
// Optional watchdog on engine response enabled by defining TT_WDOG_EN.
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module tt_query_sched
   import tt_pkg::*;
#(
   parameter int NUM_REQ        = 4,
   parameter int MAX_BEATS      = 16,
   parameter int TIMEOUT_CYCLES = 1024,
   localparam int ID_W          = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [NUM_REQ-1:0]         req_valid,
   input  logic [NUM_REQ-1:0]         req_last,
   input  logic [c_stn_w*NUM_REQ-1:0] req_src,
   input  logic [c_stn_w*NUM_REQ-1:0] req_dst,
   output logic [NUM_REQ-1:0]         req_ready,
   output logic                       rsp_valid,
   output logic [ID_W-1:0]            rsp_id,
   output logic [c_stn_w-1:0]         rsp_cost,
   output logic                       rsp_err,
   output logic                       eng_in_valid,
   output logic [c_stn_w-1:0]         eng_source,
   output logic [c_stn_w-1:0]         eng_destination,
   input  logic                       eng_out_valid,
   input  logic [c_stn_w-1:0]         eng_cost,
   output logic                       busy
);

   localparam int IDX_W = $clog2(MAX_BEATS);
   localparam int CNT_W = $clog2(MAX_BEATS + 1);

   state_t              r_state, w_state_nxt;
   logic [ID_W-1:0]     r_gid, r_rr_ptr;
   logic [CNT_W-1:0]    r_cnt, r_ridx;
   logic                r_ovf, r_tmo;
   logic [c_stn_w-1:0]  r_cost;
   beat_t               r_beat_buf [MAX_BEATS];

   logic                r_rsp_valid, r_rsp_err, r_eng_in_valid, r_busy;
   logic [ID_W-1:0]     r_rsp_id;
   logic [c_stn_w-1:0]  r_rsp_cost, r_eng_src, r_eng_dst;

   logic [NUM_REQ-1:0]  w_grant;
   logic [ID_W-1:0]     w_idx;
   logic                w_any, w_accept, w_beat_last, w_beat_ovf, w_replay_last;
   logic                w_arb_ok, w_wdog_fire;
   beat_t               w_beat;

   tt_rr_arbiter #(
      .NUM_REQ (NUM_REQ),
      .ID_W    (ID_W)
   ) u_arb (
      .req   (req_valid),
      .ptr   (r_rr_ptr),
      .grant (w_grant),
      .idx   (w_idx)
   );

   assign w_any = |w_grant;

   always_comb begin
      req_ready = '0;
      if (r_state == ST_COLLECT) req_ready[r_gid] = 1'b1;
   end

   always_comb begin
      w_beat.src = req_src[c_stn_w*r_gid +: c_stn_w];
      w_beat.dst = req_dst[c_stn_w*r_gid +: c_stn_w];
   end

   assign w_accept      = (r_state == ST_COLLECT) && req_valid[r_gid];
   assign w_beat_last   = req_last[r_gid];
   assign w_beat_ovf    = (r_cnt == CNT_W'(MAX_BEATS));
   assign w_replay_last = ((r_ridx + CNT_W'(1)) == r_cnt);

`ifdef TT_WDOG_EN
   localparam int WD_W = $clog2(TIMEOUT_CYCLES);
   logic [WD_W-1:0] r_wdog;
   logic [1:0]      r_quiet;

   assign w_wdog_fire = (r_state == ST_WAIT) && (r_wdog == WD_W'(TIMEOUT_CYCLES - 1));
   // A timed-out engine may still answer late; wait for it to go quiet first.
   assign w_arb_ok    = (r_quiet == 2'd2);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wdog  <= '0;
         r_quiet <= '0;
      end else begin
         r_wdog  <= (r_state == ST_WAIT && !eng_out_valid) ? r_wdog + 1'b1 : '0;
         if (eng_out_valid)        r_quiet <= '0;
         else if (r_quiet != 2'd2) r_quiet <= r_quiet + 1'b1;
      end
   end
`else
   logic w_unused_tmo;
   assign w_unused_tmo = (TIMEOUT_CYCLES > 0);
   assign w_wdog_fire  = 1'b0;
   assign w_arb_ok     = 1'b1;
`endif

   always_ff @(posedge clk) begin
      if (rst) r_state <= ST_ARB;
      else     r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_ARB:     if (w_any && w_arb_ok) w_state_nxt = ST_COLLECT;
         ST_COLLECT: if (w_accept && w_beat_last)
                        w_state_nxt = (r_ovf || w_beat_ovf) ? ST_RESP : ST_REPLAY;
         ST_REPLAY:  if (w_replay_last) w_state_nxt = ST_WAIT;
         ST_WAIT:    if (eng_out_valid || w_wdog_fire) w_state_nxt = ST_RESP;
         ST_RESP:    w_state_nxt = ST_ARB;
         default:    w_state_nxt = ST_ARB;
      endcase
   end

   // Beat storage carries no reset; r_cnt alone decides what is valid.
   always_ff @(posedge clk) begin
      if (w_accept && !w_beat_ovf) r_beat_buf[r_cnt[IDX_W-1:0]] <= w_beat;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_gid          <= '0;
         r_rr_ptr       <= '0;
         r_cnt          <= '0;
         r_ridx         <= '0;
         r_ovf          <= 1'b0;
         r_tmo          <= 1'b0;
         r_cost         <= '0;
         r_rsp_valid    <= 1'b0;
         r_rsp_id       <= '0;
         r_rsp_cost     <= '0;
         r_rsp_err      <= 1'b0;
         r_eng_in_valid <= 1'b0;
         r_eng_src      <= '0;
         r_eng_dst      <= '0;
         r_busy         <= 1'b0;
      end else begin
         r_rsp_valid    <= 1'b0;
         r_rsp_id       <= '0;
         r_rsp_cost     <= '0;
         r_rsp_err      <= 1'b0;
         r_eng_in_valid <= 1'b0;
         r_eng_src      <= '0;
         r_eng_dst      <= '0;
         r_busy         <= (w_state_nxt != ST_ARB);
         case (r_state)
            ST_ARB: begin
               if (w_any && w_arb_ok) begin
                  r_gid    <= w_idx;
                  r_rr_ptr <= (w_idx == ID_W'(NUM_REQ - 1)) ? '0 : w_idx + 1'b1;
               end
            end
            ST_COLLECT: begin
               if (w_accept) begin
                  if (w_beat_ovf) r_ovf <= 1'b1;
                  else            r_cnt <= r_cnt + 1'b1;
               end
            end
            ST_REPLAY: begin
               r_eng_in_valid <= 1'b1;
               r_eng_src      <= r_beat_buf[r_ridx[IDX_W-1:0]].src;
               r_eng_dst      <= r_beat_buf[r_ridx[IDX_W-1:0]].dst;
               r_ridx         <= w_replay_last ? '0 : r_ridx + 1'b1;
            end
            ST_WAIT: begin
               if (eng_out_valid)    r_cost <= eng_cost;
               else if (w_wdog_fire) r_tmo  <= 1'b1;
            end
            ST_RESP: begin
               r_rsp_valid <= 1'b1;
               r_rsp_id    <= r_gid;
               r_rsp_err   <= r_ovf | r_tmo;
               r_rsp_cost  <= (r_ovf | r_tmo) ? c_cost_unreach : r_cost;
               r_cnt       <= '0;
               r_ovf       <= 1'b0;
               r_tmo       <= 1'b0;
            end
            default: ;
         endcase
      end
   end

   assign rsp_valid       = r_rsp_valid;
   assign rsp_id          = r_rsp_id;
   assign rsp_cost        = r_rsp_cost;
   assign rsp_err         = r_rsp_err;
   assign eng_in_valid    = r_eng_in_valid;
   assign eng_source      = r_eng_src;
   assign eng_destination = r_eng_dst;
   assign busy            = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_tt_query_sched.sv
// ============================================================================
// tb_tt_query_sched : self-checking bench with engine model and reference
// Rev 1.0 : initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_tt_query_sched;

   localparam int NUM_REQ   = 4;
   localparam int MAX_BEATS = 16;

   logic                   clk = 1'b0;
   logic                   rst = 1'b1;
   logic [NUM_REQ-1:0]     req_valid = '0, req_last = '0, req_ready;
   logic [4*NUM_REQ-1:0]   req_src = '0, req_dst = '0;
   logic                   rsp_valid, rsp_err, eng_in_valid, busy;
   logic [1:0]             rsp_id;
   logic [3:0]             rsp_cost, eng_source, eng_destination;
   logic                   eng_out_valid;
   logic [3:0]             eng_cost;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int m_ptr = 0;

   logic [7:0] bur [4][32];
   int         blen [4];

   logic [6:0] rsp_q[$], exp_q[$];
   int         lat_q[$], seen_len_q[$], exp_len_q[$], gap_q[$];
   logic [7:0] seen_beat_q[$], exp_beat_q[$];
   int         pulse_cyc = 0;

   tt_query_sched dut (
      .clk             (clk),
      .rst             (rst),
      .req_valid       (req_valid),
      .req_last        (req_last),
      .req_src         (req_src),
      .req_dst         (req_dst),
      .req_ready       (req_ready),
      .rsp_valid       (rsp_valid),
      .rsp_id          (rsp_id),
      .rsp_cost        (rsp_cost),
      .rsp_err         (rsp_err),
      .eng_in_valid    (eng_in_valid),
      .eng_source      (eng_source),
      .eng_destination (eng_destination),
      .eng_out_valid   (eng_out_valid),
      .eng_cost        (eng_cost),
      .busy            (busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Shortest hop count from beat 0's src to its dst over directed edges 1..n-1.
   function automatic int sp_cost(input logic [7:0] b [32], input int n);
      int d [16];
      for (int i = 0; i < 16; i++) d[i] = 99;
      d[b[0][7:4]] = 0;
      for (int r = 0; r < 16; r++)
         for (int e = 1; e < n; e++)
            if (d[b[e][7:4]] + 1 < d[b[e][3:0]]) d[b[e][3:0]] = d[b[e][7:4]] + 1;
      return (d[b[0][3:0]] >= 99) ? 0 : d[b[0][3:0]];
   endfunction

   // Engine model: collects a gap-free burst, answers after a random latency.
   initial begin
      logic [7:0] eb [32];
      int en, lat, idle, nb;
      logic [3:0] pcost;
      en = 0; lat = 0; idle = 0; nb = 0; pcost = '0;
      eng_out_valid = 1'b0;
      eng_cost      = '0;
      forever begin
         @(negedge clk);
         eng_out_valid = 1'b0;
         eng_cost      = '0;
         if (rst) begin
            en = 0; lat = 0; idle = 0; nb = 0;
         end else begin
            if (lat > 0) begin
               lat--;
               if (lat == 0) begin
                  eng_out_valid = 1'b1;
                  eng_cost      = pcost;
                  pulse_cyc     = cyc;
               end
            end
            if (eng_in_valid) begin
               if (en == 0) begin
                  if (nb > 0) gap_q.push_back(idle);
                  nb++;
               end
               if (en < 32) eb[en] = {eng_source, eng_destination};
               en++;
               seen_beat_q.push_back({eng_source, eng_destination});
               idle = 0;
            end else begin
               if (en > 0) begin
                  seen_len_q.push_back(en);
                  pcost = 4'(sp_cost(eb, en));
                  lat   = $urandom_range(1, 6);
                  en    = 0;
               end
               idle++;
            end
         end
      end
   end

   initial begin
      forever begin
         @(negedge clk);
         if (rsp_valid) begin
            rsp_q.push_back({rsp_id, rsp_err, rsp_cost});
            lat_q.push_back(cyc - pulse_cyc);
         end
      end
   end

   task automatic fill_rand(input int k, input int len);
      blen[k] = len;
      for (int i = 0; i < len; i++)
         bur[k][i] = {4'($urandom_range(0, 7)), 4'($urandom_range(0, 7))};
   endtask

   task automatic run_round(input logic [3:0] mask, input int stall_id, input int stall_at,
                            input int stall_len, input bit rnd_stall);
      int pos [4];
      int n_exp, stall_left, w, cand;
      logic [3:0] taken, acc;
      logic [7:0] tmp [32];
      bit done, err;
      logic [6:0] got, e;
      n_exp = 0; taken = '0; stall_left = stall_len; done = 1'b0;
      // Reference: round-robin order over the requesters pending in this round.
      for (int j = 0; j < 4; j++) begin
         if (mask[j]) begin
            w = -1;
            for (int k = 0; k < 4; k++) begin
               cand = (m_ptr + k) % 4;
               if (w < 0 && mask[cand] && !taken[cand]) w = cand;
            end
            taken[w] = 1'b1;
            m_ptr    = (w + 1) % 4;
            err      = (blen[w] > MAX_BEATS);
            for (int i = 0; i < 32; i++) tmp[i] = bur[w][i];
            exp_q.push_back({2'(w), err, err ? 4'd0 : 4'(sp_cost(tmp, blen[w]))});
            n_exp++;
            if (!err) begin
               exp_len_q.push_back(blen[w]);
               for (int i = 0; i < blen[w]; i++) exp_beat_q.push_back(bur[w][i]);
            end
         end
      end
      for (int k = 0; k < 4; k++) pos[k] = 0;
      for (int c = 0; c < 4000; c++) begin
         @(negedge clk);
         req_valid = '0; req_last = '0; req_src = '0; req_dst = '0;
         done = (rsp_q.size() >= n_exp);
         for (int k = 0; k < 4; k++) if (mask[k] && pos[k] < blen[k]) done = 1'b0;
         if (done) break;
         for (int k = 0; k < 4; k++) begin
            if (mask[k] && pos[k] < blen[k]) begin
               if (k == stall_id && pos[k] == stall_at && stall_left > 0) stall_left--;
               else if (rnd_stall && pos[k] > 0 && $urandom_range(0, 3) == 0) ;
               else begin
                  req_valid[k]        = 1'b1;
                  req_last[k]         = (pos[k] == blen[k] - 1);
                  req_src[4*k +: 4]   = bur[k][pos[k]][7:4];
                  req_dst[4*k +: 4]   = bur[k][pos[k]][3:0];
               end
            end
         end
         acc = req_valid & req_ready;
         @(posedge clk);
         for (int k = 0; k < 4; k++) if (acc[k]) pos[k]++;
      end
      chk("round_completed", 32'(done), 32'd1);
      for (int i = 0; i < n_exp; i++) begin
         e   = exp_q.pop_front();
         got = (rsp_q.size() > 0) ? rsp_q.pop_front() : 7'bx;
         chk($sformatf("rsp%0d_id", i),   32'(got[6:5]), 32'(e[6:5]));
         chk($sformatf("rsp%0d_err", i),  32'(got[4]),   32'(e[4]));
         chk($sformatf("rsp%0d_cost", i), 32'(got[3:0]), 32'(e[3:0]));
         if (lat_q.size() > 0) begin
            w = lat_q.pop_front();
            if (!e[4]) chk($sformatf("rsp%0d_latency", i), 32'(w), 32'd2);
         end
      end
      chk("extra_responses", 32'(rsp_q.size()), 32'd0);
      while (exp_len_q.size() > 0) begin
         w = exp_len_q.pop_front();
         chk("eng_burst_len", (seen_len_q.size() > 0) ? 32'(seen_len_q.pop_front()) : 32'hffff, 32'(w));
         for (int i = 0; i < w; i++)
            chk($sformatf("eng_beat%0d", i),
                (seen_beat_q.size() > 0) ? 32'(seen_beat_q.pop_front()) : 32'hffff,
                32'(exp_beat_q.pop_front()));
      end
      chk("extra_eng_bursts", 32'(seen_len_q.size()), 32'd0);
      while (gap_q.size() > 0) chk("eng_gap_ge3", 32'(gap_q.pop_front() >= 3), 32'd1);
      seen_beat_q.delete();
      lat_q.delete();
   endtask

   task automatic check_all_zero(input string tg);
      chk({tg, "_rsp_valid"},    32'(rsp_valid), 32'd0);
      chk({tg, "_rsp_id"},       32'(rsp_id), 32'd0);
      chk({tg, "_rsp_cost"},     32'(rsp_cost), 32'd0);
      chk({tg, "_rsp_err"},      32'(rsp_err), 32'd0);
      chk({tg, "_eng_in_valid"}, 32'(eng_in_valid), 32'd0);
      chk({tg, "_eng_source"},   32'(eng_source), 32'd0);
      chk({tg, "_eng_dest"},     32'(eng_destination), 32'd0);
      chk({tg, "_busy"},         32'(busy), 32'd0);
      chk({tg, "_req_ready"},    32'(req_ready), 32'd0);
   endtask

   initial begin
      int pos0;
      bit seen;
      logic [3:0] acc;
      repeat (3) @(posedge clk);
      #1 check_all_zero("reset");
      @(negedge clk) rst = 1'b0;

      // Single requester, cost 3 via 0-1-2-3.
      blen[0] = 4;
      bur[0][0] = 8'h03; bur[0][1] = 8'h01; bur[0][2] = 8'h12; bur[0][3] = 8'h23;
      run_round(4'b0001, -1, 0, 0, 1'b0);

      // Round-robin: req1 and req3 together, then req0 and req3 together.
      fill_rand(1, 5); fill_rand(3, 3);
      run_round(4'b1010, -1, 0, 0, 1'b0);
      fill_rand(1, 4);
      run_round(4'b0010, -1, 0, 0, 1'b0);
      fill_rand(0, 6); fill_rand(3, 2);
      run_round(4'b1001, -1, 0, 0, 1'b0);

      // Stalled burst on req2 gives the same contiguous replay.
      blen[2] = 4;
      bur[2][0] = 8'h03; bur[2][1] = 8'h01; bur[2][2] = 8'h12; bur[2][3] = 8'h23;
      run_round(4'b0100, 2, 2, 5, 1'b0);

      // Overflow at 18 and 17 beats; exactly MAX_BEATS still replays.
      fill_rand(1, 18); fill_rand(2, 16); fill_rand(3, 17);
      run_round(4'b1110, -1, 0, 0, 1'b0);

      // Unreachable destination.
      blen[3] = 2; bur[3][0] = 8'h05; bur[3][1] = 8'h01;
      run_round(4'b1000, -1, 0, 0, 1'b0);

      for (int r = 0; r < 8; r++) begin
         for (int k = 0; k < 4; k++) fill_rand(k, $urandom_range(1, 12));
         if (r == 5) fill_rand(2, 20);
         run_round(4'($urandom_range(1, 15)), -1, 0, 0, 1'b1);
      end

      // Reset during replay drops the query.
      fill_rand(0, 6);
      pos0 = 0;
      for (int c = 0; c < 200 && pos0 < 6; c++) begin
         @(negedge clk);
         req_valid = '0; req_last = '0; req_src = '0; req_dst = '0;
         req_valid[0] = 1'b1;
         req_last[0]  = (pos0 == 5);
         req_src[3:0] = bur[0][pos0][7:4];
         req_dst[3:0] = bur[0][pos0][3:0];
         acc = req_valid & req_ready;
         @(posedge clk);
         if (acc[0]) pos0++;
      end
      @(negedge clk);
      req_valid = '0; req_last = '0;
      chk("busy_before_replay", 32'(busy), 32'd1);
      seen = 1'b0;
      for (int c = 0; c < 100 && !seen; c++) begin
         @(negedge clk);
         seen = eng_in_valid;
      end
      chk("replay_started", 32'(seen), 32'd1);
      @(negedge clk);
      chk("replay_beat2_valid", 32'(eng_in_valid), 32'd1);
      rst = 1'b1;
      @(posedge clk);
      #1 check_all_zero("mid_reset");
      @(negedge clk);
      @(negedge clk) rst = 1'b0;
      m_ptr = 0;
      seen_beat_q.delete(); seen_len_q.delete(); gap_q.delete(); lat_q.delete();
      repeat (30) @(negedge clk);
      chk("no_rsp_after_reset", 32'(rsp_q.size()), 32'd0);
      chk("no_eng_burst_after_reset", 32'(seen_len_q.size()), 32'd0);
      rsp_q.delete();

      fill_rand(0, 5);
      run_round(4'b0001, -1, 0, 0, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire
